// File: rtl/gvn_expr_sched.sv
// gvn_expr_sched: global value numbering scheduler for 1-bit expressions.
// Redundant requests reuse an existing slot; new ones issue on one shared ALU.
module gvn_expr_sched #(
    parameter int NUM_VN = 8,
    parameter int VN_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pi_a,
    input  logic            pi_b,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [VN_W-1:0] in_src_a,
    input  logic [VN_W-1:0] in_src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VN_W-1:0] out_vn,
    output logic            out_val,
    output logic            out_hit,
    output logic            out_err,
    output logic            busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    logic [1:0] state;

    logic [NUM_VN-1:0] tv;
    logic [NUM_VN-1:0] tval;
    logic [1:0]        top [NUM_VN];
    logic [VN_W-1:0]   tka [NUM_VN];
    logic [VN_W-1:0]   tkb [NUM_VN];

    logic [1:0]      r_op;
    logic [VN_W-1:0] r_a;
    logic [VN_W-1:0] r_b;
    logic [VN_W-1:0] r_slot;

    logic [VN_W-1:0] o_vn;
    logic            o_val;
    logic            o_hit;
    logic            o_err;

    logic [VN_W-1:0] ka;
    logic [VN_W-1:0] kb;
    logic            a_ok;
    logic            b_ok;
    logic            src_ok;
    logic            hit;
    logic [VN_W-1:0] hit_idx;
    logic            free_ok;
    logic [VN_W-1:0] free_idx;
    logic            alu;

    assign in_ready  = (state == S_IDLE) && !start;
    assign out_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign out_vn    = o_vn;
    assign out_val   = o_val;
    assign out_hit   = o_hit;
    assign out_err   = o_err;

    // Commutative ops are keyed with the smaller operand first
    always_comb begin
        ka = r_a;
        kb = r_b;
        if (r_op == OP_NOT) begin
            kb = '0;
        end else if (r_b < r_a) begin
            ka = r_b;
            kb = r_a;
        end
    end

    always_comb begin
        a_ok   = (int'(r_a) < NUM_VN) && tv[r_a];
        b_ok   = (int'(r_b) < NUM_VN) && tv[r_b];
        src_ok = a_ok && (b_ok || (r_op == OP_NOT));
    end

    // Descending scan so the lowest matching / free index wins
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = NUM_VN - 1; i >= 2; i--) begin
            if (tv[i] && top[i] == r_op &&
                tka[i] == ka && tkb[i] == kb) begin
                hit     = 1'b1;
                hit_idx = VN_W'(i);
            end
            if (!tv[i]) begin
                free_ok  = 1'b1;
                free_idx = VN_W'(i);
            end
        end
    end

    always_comb begin
        alu = 1'b0;
        unique case (1'b1)
            (r_op == OP_AND): alu = tval[ka] & tval[kb];
            (r_op == OP_OR):  alu = tval[ka] | tval[kb];
            (r_op == OP_XOR): alu = tval[ka] ^ tval[kb];
            (r_op == OP_NOT): alu = ~tval[ka];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv   <= NUM_VN'(3);
            tval <= '0;
        end else if (state == S_IDLE && start) begin
            tv      <= NUM_VN'(3);
            tval[0] <= pi_a;
            tval[1] <= pi_b;
        end else if (state == S_EXEC) begin
            tv[r_slot]   <= 1'b1;
            tval[r_slot] <= alu;
        end
    end

    // Expression payload is only meaningful where tv is set
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            top[r_slot] <= r_op;
            tka[r_slot] <= ka;
            tkb[r_slot] <= kb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_slot <= '0;
            o_vn   <= '0;
            o_val  <= 1'b0;
            o_hit  <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && !start) begin
                        r_op  <= in_op;
                        r_a   <= in_src_a;
                        r_b   <= in_src_b;
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!src_ok || (!hit && !free_ok)) begin
                        o_vn  <= '0;
                        o_val <= 1'b0;
                        o_hit <= 1'b0;
                        o_err <= 1'b1;
                        state <= S_RESP;
                    end else if (hit) begin
                        o_vn  <= hit_idx;
                        o_val <= tval[hit_idx];
                        o_hit <= 1'b1;
                        o_err <= 1'b0;
                        state <= S_RESP;
                    end else begin
                        r_slot <= free_idx;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    o_vn  <= r_slot;
                    o_val <= alu;
                    o_hit <= 1'b0;
                    o_err <= 1'b0;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (out_ready) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gvn_expr_sched.sv
// tb_gvn_expr_sched: directed vector table plus hand sequences for
// start conflicts, response back-pressure and reset during EXEC.
module tb_gvn_expr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pi_a = 1'b0;
    logic       pi_b = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = '0;
    logic [2:0] in_src_a = '0;
    logic [2:0] in_src_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_vn;
    logic       out_val;
    logic       out_hit;
    logic       out_err;
    logic       busy;

    gvn_expr_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pi_a(pi_a), .pi_b(pi_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vn(out_vn), .out_val(out_val),
        .out_hit(out_hit), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] AND_ = 2'd0;
    localparam logic [1:0] OR_  = 2'd1;
    localparam logic [1:0] XOR_ = 2'd2;
    localparam logic [1:0] NOT_ = 2'd3;

    typedef struct {
        bit         is_start;
        bit         a;
        bit         b;
        logic [1:0] op;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [2:0] vn;
        bit         val;
        bit         hit;
        bit         err;
        int         lat;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_r(input logic [1:0] op, input int sa, input int sb,
                         input int vn, input bit val, input bit hit,
                         input bit err, input int lat);
        vec_t v;
        v.is_start = 1'b0;
        v.a = 1'b0;
        v.b = 1'b0;
        v.op = op;
        v.sa = 3'(sa);
        v.sb = 3'(sb);
        v.vn = 3'(vn);
        v.val = val;
        v.hit = hit;
        v.err = err;
        v.lat = lat;
        vecs[nv] = v;
        nv++;
    endtask

    task automatic add_s(input bit a, input bit b);
        vec_t v;
        v = '{1'b1, a, b, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0};
        vecs[nv] = v;
        nv++;
    endtask

    // Called at a negedge with the DUT idle
    task automatic run_start(input string nm, input bit a, input bit b);
        start = 1'b1;
        pi_a = a;
        pi_b = b;
        #1;
        chk({nm, " in_ready"}, in_ready, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({nm, " busy"}, busy, 0);
    endtask

    // Latency counts rising edges from the accept edge to out_valid
    task automatic run_req(input string nm, input vec_t v);
        int lat;
        bit got;
        in_valid = 1'b1;
        in_op = v.op;
        in_src_a = v.sa;
        in_src_b = v.sb;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        repeat (8) begin
            if (!got) begin
                @(negedge clk);
                if (out_valid) got = 1'b1;
                else begin
                    @(posedge clk);
                    lat++;
                end
            end
        end
        chk({nm, " out_valid"}, got, 1);
        if (got) begin
            chk({nm, " lat"}, lat, v.lat);
            chk({nm, " vn"}, out_vn, v.vn);
            chk({nm, " val"}, out_val, v.val);
            chk({nm, " hit"}, out_hit, v.hit);
            chk({nm, " err"}, out_err, v.err);
            @(posedge clk);
            @(negedge clk);
            chk({nm, " idle"}, busy, 0);
        end
    endtask

    initial begin
        logic [2:0] h_vn;
        logic       h_val;
        vec_t       v;

        add_s(1, 0);
        add_r(NOT_, 0, 0, 2, 0, 0, 0, 3);
        add_r(AND_, 2, 1, 3, 0, 0, 0, 3);
        add_r(AND_, 1, 2, 3, 0, 1, 0, 2);
        add_r(NOT_, 0, 5, 2, 0, 1, 0, 2);
        add_r(XOR_, 0, 1, 4, 1, 0, 0, 3);
        add_r(NOT_, 1, 0, 5, 1, 0, 0, 3);
        add_r(AND_, 0, 5, 6, 1, 0, 0, 3);
        add_r(OR_,  3, 6, 7, 1, 0, 0, 3);
        add_r(OR_,  0, 1, 0, 0, 0, 1, 2);
        add_r(XOR_, 1, 0, 4, 1, 1, 0, 2);
        add_r(OR_,  6, 3, 7, 1, 1, 0, 2);
        add_r(AND_, 5, 0, 6, 1, 1, 0, 2);
        add_r(NOT_, 7, 0, 0, 0, 0, 1, 2);
        add_s(0, 1);
        add_r(AND_, 2, 5, 0, 0, 0, 1, 2);
        add_r(XOR_, 0, 1, 2, 1, 0, 0, 3);
        add_r(NOT_, 1, 7, 3, 0, 0, 0, 3);
        add_r(AND_, 2, 3, 4, 0, 0, 0, 3);
        add_r(NOT_, 1, 2, 3, 0, 1, 0, 2);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_vn", out_vn, 0);
        chk("rst out_val", out_val, 0);
        chk("rst out_hit", out_hit, 0);
        chk("rst out_err", out_err, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1;
        #1 chk("rst in_ready", in_ready, 1);
        @(negedge clk);

        // start wins over a simultaneous request
        in_valid = 1'b1;
        in_op = NOT_;
        in_src_a = 3'd0;
        run_start("start+req", 1, 0);
        in_valid = 1'b0;
        chk("start+req no_resp", out_valid, 0);

        for (int i = 0; i < nv; i++) begin
            if (vecs[i].is_start)
                run_start($sformatf("v%0d start", i), vecs[i].a, vecs[i].b);
            else
                run_req($sformatf("v%0d", i), vecs[i]);
        end

        // Error response held under back-pressure; start is ignored
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = AND_;
        in_src_a = 3'd0;
        in_src_b = 3'd6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("hold early", out_valid, 0);
        @(negedge clk);
        chk("hold out_valid", out_valid, 1);
        chk("hold out_err", out_err, 1);
        h_vn = out_vn;
        h_val = out_val;
        chk("hold vn0", h_vn, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                start = 1'b1;
                pi_a = 1'b1;
                pi_b = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), out_valid, 1);
            chk($sformatf("hold%0d err", k), out_err, 1);
            chk($sformatf("hold%0d vn", k), out_vn, h_vn);
            chk($sformatf("hold%0d val", k), out_val, h_val);
            chk($sformatf("hold%0d hit", k), out_hit, 0);
            chk($sformatf("hold%0d busy", k), busy, 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold release", busy, 0);

        // Table must survive the ignored start
        v = vecs[0];
        v.is_start = 1'b0;
        v.op = XOR_;
        v.sa = 3'd1;
        v.sb = 3'd0;
        v.vn = 3'd2;
        v.val = 1'b1;
        v.hit = 1'b1;
        v.err = 1'b0;
        v.lat = 2;
        run_req("post-hold", v);

        // Reset while the miss is in EXEC
        in_valid = 1'b1;
        in_op = OR_;
        in_src_a = 3'd0;
        in_src_b = 3'd1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 chk("exec busy", busy, 1);
        chk("exec out_valid", out_valid, 0);
        #2 rst_n = 1'b0;
        #1 chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        chk("abort no_resp", out_valid, 0);
        v.op = OR_;
        v.sa = 3'd0;
        v.sb = 3'd1;
        v.vn = 3'd2;
        v.val = 1'b0;
        v.hit = 1'b0;
        v.err = 1'b0;
        v.lat = 3;
        run_req("post-abort", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gvn_expr_sched.md
GVN_EXPR_SCHED -- requirements
Module: gvn_expr_sched

Interface
REQ-001 Parameter: NUM_VN, default 8, number of value-number slots; slots 0 and 1 are primary inputs, slots 2..NUM_VN-1 are allocatable.
REQ-002 Parameter: VN_W, default 3, value-number index width, equal to clog2(NUM_VN).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  loads pi_a/pi_b and clears the table; honoured only in IDLE.
REQ-006 Port: pi_a, pi_b  input  1 each  primary inputs, written to slots 0 and 1 on start.
REQ-007 Port: in_valid  input  1, in_ready  output  1  expression request handshake.
REQ-008 Port: in_op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NOT.
REQ-009 Port: in_src_a, in_src_b  input  VN_W each  operand value numbers; in_src_b is ignored for NOT.
REQ-010 Port: out_valid  output  1, out_ready  input  1  response handshake.
REQ-011 Port: out_vn  output  VN_W  value number holding the result.
REQ-012 Port: out_val  output  1  result bit.
REQ-013 Port: out_hit  output  1  1 = redundant expression reused an existing slot, with no ALU issue.
REQ-014 Port: out_err  output  1  1 = the request was rejected (invalid source or table full).
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL hold a value table with, per slot: valid, op, key_a, key_b, val; slots 0/1 are valid with op = NOT-applicable and are never matched by lookups.
REQ-017 FSM states SHALL be IDLE, LOOKUP, EXEC, RESP; in_ready = 1 only in IDLE with start = 0.
REQ-018 Request accept (in_valid & in_ready) in IDLE -> register the request, then LOOKUP.
REQ-019 Canonicalization in LOOKUP: for AND/OR/XOR, key_a = min(src_a, src_b) and key_b = max(src_a, src_b); for NOT, key_a = src_a and key_b = 0.
REQ-020 Validity check in LOOKUP: if any used source slot is invalid, go to RESP with out_err = 1, out_vn = 0, out_val = 0, and no allocation.
REQ-021 Hit in LOOKUP (a valid slot >= 2 with equal op, key_a, key_b; lowest index wins) -> RESP with out_hit = 1, out_vn = that slot, out_val = its val.
REQ-022 Miss in LOOKUP -> EXEC, with the free slot = lowest invalid index >= 2.
REQ-023 No free slot on a miss -> RESP with out_err = 1; no table write.
REQ-024 EXEC SHALL evaluate the op on the single shared 1-bit ALU, write the slot (valid = 1, op, keys, val), then go to RESP with out_hit = 0 and out_vn = the new slot.
REQ-025 Latency from the accept edge to out_valid: hit or error = 2 cycles; miss = 3 cycles.
REQ-026 RESP SHALL hold out_valid and all out_* fields stable until out_ready = 1, then return to IDLE; out_valid = 0 in every other state.
REQ-027 The ALU SHALL be used only in EXEC, at most one op per request.
REQ-028 Start in IDLE: slot0.val = pi_a, slot1.val = pi_b, slots 2..NUM_VN-1 set invalid, with a one-cycle in_ready = 0.
REQ-029 If start and in_valid are both high in IDLE, start wins and the request is not accepted.
REQ-030 Start outside IDLE SHALL be ignored.
REQ-031 Slots 0/1 SHALL remain valid after start and after reset.

Reset
REQ-032 When rst_n = 0: state = IDLE, all slot valid bits = 0 except slots 0/1, slot0/slot1 val = 0, and out_valid, out_vn, out_val, out_hit, out_err, busy = 0.
REQ-033 After reset is released, in_ready SHALL be 1 on the first cycle.
REQ-034 Reset asserted mid-operation SHALL abort the request, drop any pending response, and produce no table write on that or later edges.

Verification
REQ-035 Pulse start with pi_a=1, pi_b=0; issue NOT src_a=0 -> 3 cycles later out_vn=2, out_val=0, out_hit=0; then AND(2,1) -> out_vn=3, out_val=0, out_hit=0.
REQ-036 With the state from REQ-035, issue AND(1,2) (commuted) -> 2 cycles later out_vn=3, out_hit=1, out_val=0; then NOT src_a=0 again -> out_vn=2, out_hit=1.
REQ-037 With a=1, b=0: issue NOT(1), AND(0,3'), XOR(0,1), OR(t1,t2) -> XOR gives out_val=1; OR of slot 3 and the AND slot gives out_val=1; all are misses with unique vns.
REQ-038 Fill all slots 2..7, then issue a new distinct expression -> out_err=1, out_hit=0, table unchanged; a repeat of an existing expression still gets out_hit=1.
REQ-039 Issue AND(0,6) with slot 6 invalid -> out_err=1 after 2 cycles; hold out_ready=0 for 4 cycles -> out_* fields stable, busy=1.
REQ-040 Assert rst_n=0 during EXEC -> out_valid=0, and after release a lookup of the aborted expression misses and allocates slot 2.
